// File: rtl/axi_lite_read_arbiter.sv
// Two-requester round-robin AXI4-Lite read master: one transaction in flight at a time,
// carried through IDLE -> ADDR -> DATA -> RESP.
module axi_lite_read_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  output logic [1:0]        rsp0_resp,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  output logic [1:0]        rsp1_resp,
  output logic [ADDR_W-1:0] M_AXI_ARADDR,
  output logic              M_AXI_ARVALID,
  input  logic              M_AXI_ARREADY,
  input  logic [DATA_W-1:0] M_AXI_RDATA,
  input  logic [1:0]        M_AXI_RRESP,
  input  logic              M_AXI_RVALID,
  output logic              M_AXI_RREADY,
  output logic              busy,
  output logic [CNT_W-1:0]  txn_count
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t state, state_next;
  logic   any_req, grant, accept, capture;
  logic   last_grant, grant_id;

  // Grant and request handshake decode; only meaningful while IDLE.
  always_comb begin
    any_req    = req0_valid | req1_valid;
    grant      = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    accept     = (state == IDLE) && any_req;
    capture    = (state == DATA) && M_AXI_RVALID;
    req0_ready = accept && !grant;
    req1_ready = accept && grant;
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = ADDR;
      ADDR:    if (M_AXI_ARREADY) state_next = DATA;
      DATA:    if (M_AXI_RVALID) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs are registered decodes of the next state.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      grant_id      <= 1'b0;
      M_AXI_ARADDR  <= '0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      busy          <= 1'b0;
      rsp0_valid    <= 1'b0;
      rsp0_data     <= '0;
      rsp0_resp     <= '0;
      rsp1_valid    <= 1'b0;
      rsp1_data     <= '0;
      rsp1_resp     <= '0;
      txn_count     <= '0;
    end else begin
      state         <= state_next;
      M_AXI_ARVALID <= (state_next == ADDR);
      M_AXI_RREADY  <= (state_next == DATA);
      busy          <= (state_next != IDLE);
      rsp0_valid    <= 1'b0;
      rsp1_valid    <= 1'b0;
      if (accept) begin
        M_AXI_ARADDR <= grant ? req1_addr : req0_addr;
        grant_id     <= grant;
        last_grant   <= grant;
      end
      // Response registers are per requester so the idle one keeps its last beat.
      if (capture) begin
        if (grant_id) begin
          rsp1_valid <= 1'b1;
          rsp1_data  <= M_AXI_RDATA;
          rsp1_resp  <= M_AXI_RRESP;
        end else begin
          rsp0_valid <= 1'b1;
          rsp0_data  <= M_AXI_RDATA;
          rsp0_resp  <= M_AXI_RRESP;
        end
        txn_count <= txn_count + 1'b1;
      end
    end
  end

endmodule
